// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between two writers: A (execute-stage
//   writeback) and B (I/O load unit). Each writer feeds a one-entry holding buffer through
//   a valid/ready handshake, and full buffers are served round-robin. Writes to the
//   read-only low addresses are consumed and then dropped, with a one-cycle error pulse.
//
// Ports
//   clock, reset_n                  rising-edge clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data   requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data   requester B handshake and payload
//   we, wr_addr, wr_data            registered register-file write port
//   pending[N-1:0]                  per-address "write in flight" mask for hazard detection
//   drop_err                        one-cycle pulse after a read-only write is rejected
//   stall_cnt                       saturating count of edges where both buffers are full
module regfile_write_arbiter #(
    parameter int unsigned BUS_WIDTH       = 8,
    parameter int unsigned ADDR_WIDTH      = 3,
    parameter int unsigned FIRST_WRITABLE  = 4,
    parameter int unsigned STALL_CNT_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    input  logic [BUS_WIDTH-1:0]         a_data,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    input  logic [BUS_WIDTH-1:0]         b_data,
    output logic                         we,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [BUS_WIDTH-1:0]         wr_data,
    output logic [(2**ADDR_WIDTH)-1:0]   pending,
    output logic                         drop_err,
    output logic [STALL_CNT_WIDTH-1:0]   stall_cnt
);

    localparam int unsigned N = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] FirstWr = ADDR_WIDTH'(FIRST_WRITABLE);

    // Round-robin pointer: which requester wins when both buffers are full.
    typedef enum logic {PrioA, PrioB} prio_e;

    prio_e                        prio_q, prio_d;
    logic                         hold_a_full_q, hold_a_full_d;
    logic [ADDR_WIDTH-1:0]        hold_a_addr_q, hold_a_addr_d;
    logic [BUS_WIDTH-1:0]         hold_a_data_q, hold_a_data_d;
    logic                         hold_b_full_q, hold_b_full_d;
    logic [ADDR_WIDTH-1:0]        hold_b_addr_q, hold_b_addr_d;
    logic [BUS_WIDTH-1:0]         hold_b_data_q, hold_b_data_d;
    logic                         we_q, we_d;
    logic [ADDR_WIDTH-1:0]        wr_addr_q, wr_addr_d;
    logic [BUS_WIDTH-1:0]         wr_data_q, wr_data_d;
    logic                         drop_err_q, drop_err_d;
    logic [STALL_CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

    logic grant_a, grant_b;
    logic acc_a, acc_b;
    logic wr_ok_a, wr_ok_b;

    // Grants and readiness come from registered state only, so ready never
    // combinationally depends on the requester's valid or payload.
    always_comb begin
        grant_a = hold_a_full_q && (!hold_b_full_q || (prio_q == PrioA));
        grant_b = hold_b_full_q && (!hold_a_full_q || (prio_q == PrioB));
        a_ready = !hold_a_full_q || grant_a;
        b_ready = !hold_b_full_q || grant_b;
        acc_a   = a_valid && a_ready;
        acc_b   = b_valid && b_ready;
        wr_ok_a = (a_addr >= FirstWr);
        wr_ok_b = (b_addr >= FirstWr);
    end

    always_comb begin
        hold_a_full_d = hold_a_full_q && !grant_a;
        hold_a_addr_d = hold_a_addr_q;
        hold_a_data_d = hold_a_data_q;
        hold_b_full_d = hold_b_full_q && !grant_b;
        hold_b_addr_d = hold_b_addr_q;
        hold_b_data_d = hold_b_data_q;
        we_d          = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        prio_d        = prio_q;
        drop_err_d    = (acc_a && !wr_ok_a) || (acc_b && !wr_ok_b);
        stall_cnt_d   = stall_cnt_q;

        // A buffer draining this edge can be refilled at the same edge.
        if (acc_a && wr_ok_a) begin
            hold_a_full_d = 1'b1;
            hold_a_addr_d = a_addr;
            hold_a_data_d = a_data;
        end
        if (acc_b && wr_ok_b) begin
            hold_b_full_d = 1'b1;
            hold_b_addr_d = b_addr;
            hold_b_data_d = b_data;
        end

        if (grant_a) begin
            we_d      = 1'b1;
            wr_addr_d = hold_a_addr_q;
            wr_data_d = hold_a_data_q;
            prio_d    = PrioB;
        end else if (grant_b) begin
            we_d      = 1'b1;
            wr_addr_d = hold_b_addr_q;
            wr_data_d = hold_b_data_q;
            prio_d    = PrioA;
        end

        if (hold_a_full_q && hold_b_full_q && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q        <= PrioA;
            hold_a_full_q <= 1'b0;
            hold_a_addr_q <= '0;
            hold_a_data_q <= '0;
            hold_b_full_q <= 1'b0;
            hold_b_addr_q <= '0;
            hold_b_data_q <= '0;
            we_q          <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            drop_err_q    <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            prio_q        <= prio_d;
            hold_a_full_q <= hold_a_full_d;
            hold_a_addr_q <= hold_a_addr_d;
            hold_a_data_q <= hold_a_data_d;
            hold_b_full_q <= hold_b_full_d;
            hold_b_addr_q <= hold_b_addr_d;
            hold_b_data_q <= hold_b_data_d;
            we_q          <= we_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            drop_err_q    <= drop_err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < N; i++) begin
            pending[i] = (hold_a_full_q && (hold_a_addr_q == ADDR_WIDTH'(i)))
                       | (hold_b_full_q && (hold_b_addr_q == ADDR_WIDTH'(i)))
                       | (we_q && (wr_addr_q == ADDR_WIDTH'(i)));
        end
    end

    assign we        = we_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign drop_err  = drop_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule
